knn_sort: RTL and testbench
===========================

# knn_sort

Downstream stage of the KNN distance core: accepts a stream of (distance, label) pairs and keeps the K smallest distances in a sorted insertion buffer. On request, it runs a majority vote over the stored labels to produce the classification result. It sits between the distance datapath and the software register file, which reads the sorted list and the vote result.

## Interface
- `DATA_W`, 32, distance width (unsigned)
- `LABEL_W`, 4, class label width
- `K`, 4, number of neighbours kept (≥2)
- `IDX_W`, $clog2(K), entry index width
- `CNT_W`, $clog2(K+1), count/vote width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  start new query: empty list, abort vote
- `dist_valid`  in  1  distance/label pair present
- `dist_ready`  out  1  block can accept a pair
- `dist_in`  in  DATA_W  distance value
- `label_in`  in  LABEL_W  label of training point
- `classify`  in  1  start majority vote (pulse)
- `busy`  out  1  vote in progress
- `result_valid`  out  1  result fields are valid
- `result_label`  out  LABEL_W  winning label
- `result_votes`  out  CNT_W  votes for winning label
- `count`  out  CNT_W  valid entries, saturates at K
- `rd_addr`  in  IDX_W  sorted entry to read
- `rd_dist`  out  DATA_W  registered distance of entry rd_addr
- `rd_label`  out  LABEL_W  registered label of entry rd_addr
- `rd_vld`  out  1  registered valid bit of entry rd_addr

## Operation
- Storage: K entries {dist, label, vld}, entry 0 closest; valid entries contiguous from 0 and ascending by dist.
- Accept: `dist_valid && dist_ready`; `dist_ready = !busy`.
- Insert position p = number of valid entries with dist ≤ dist_in. Equal distances are stable: the new entry goes after existing equals.
- p < K: entries p..K-2 shift to p+1..K-1, new pair written at p, old entry K-1 dropped. p == K: pair discarded, list unchanged.
- `count` = min(count+1, K) on accept (including the discard case, since the list is full there).
- An accepted insertion clears `result_valid`.
- FSM states IDLE, SCAN, DONE:
  - IDLE → SCAN on `classify` with count>0; idx=0, best_votes=0.
  - `classify` with count==0 → DONE directly with label 0, votes 0.
  - SCAN, one entry per cycle: if entry idx is valid, v = number of valid entries whose label equals label[idx]. If v > best_votes, take label[idx] and v as best. A tie keeps the earlier (closer) entry.
  - SCAN → DONE after idx = K-1.
  - DONE: `result_valid`=1, result fields loaded from best; → IDLE next cycle. `result_valid` then holds until clear, accepted insertion, or new classify.
- `classify` while busy is ignored.
- `clear` (highest priority): all vld=0, count=0, FSM→IDLE, `result_valid`=0. A simultaneous `dist_valid` or `classify` is ignored.
- Readout: rd_* register entry rd_addr each cycle; an invalid entry reads dist 0, label 0, vld 0.

## Timing
- Reset values: all vld=0; count=0; FSM IDLE; busy=0; `dist_ready`=1; `result_valid`=0; `result_label`=0; `result_votes`=0; rd_*=0.
- Insertion is single-cycle: the pair accepted at edge t is visible in storage and `count` after t. rd_* reflect it at edge t+1.
- `classify` sampled at edge t: busy=1 from t to t+K; `result_valid`=1 after edge t+K+1. With count==0, `result_valid`=1 after edge t+1.
- `dist_ready` is low exactly while busy.
- Reset asserted mid-SCAN returns every output to its reset value immediately.

## Test plan
- Reset: after rst, count=0, `dist_ready`=1, `result_valid`=0; reading addr 0..3 gives vld=0, dist=0.
- Ordering/drop (K=4): insert (50,1), (20,2), (70,3), (20,3), (10,1) → list 10/1, 20/2, 20/3, 50/1; count=4; 70 dropped.
- Vote: then classify → busy for 4 cycles, `result_valid` 5 cycles after classify, label=1, votes=2.
- Tie/discard: list 5/2, 6/3, 7/2, 8/3; classify → label 2, votes 2. Then insert (9,1) → discarded, list and count unchanged, `result_valid` cleared.
- Busy backpressure: `dist_valid` held during SCAN → `dist_ready`=0 and no change until DONE. `classify` during SCAN → no restart.
- Clear mid-scan and empty classify: clear at SCAN idx 1 → busy=0, count=0, `result_valid`=0 next cycle. Classify on the empty list → `result_valid`=1 next cycle with label 0, votes 0.

Source files
------------

// File: rtl/knn_sort.sv
// K-nearest-neighbour sorted insertion buffer with majority-vote classifier.
// Keeps the K smallest (distance, label) pairs and votes over their labels.
module knn_sort #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4,
    parameter int K       = 4,
    parameter int IDX_W   = $clog2(K),
    parameter int CNT_W   = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               dist_valid,
    output logic               dist_ready,
    input  logic [DATA_W-1:0]  dist_in,
    input  logic [LABEL_W-1:0] label_in,
    input  logic               classify,
    output logic               busy,
    output logic               result_valid,
    output logic [LABEL_W-1:0] result_label,
    output logic [CNT_W-1:0]   result_votes,
    output logic [CNT_W-1:0]   count,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_vld
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0]  dist_q [K];
    logic [DATA_W-1:0]  dist_d [K];
    logic [LABEL_W-1:0] lab_q  [K];
    logic [LABEL_W-1:0] lab_d  [K];
    logic [K-1:0]       vld_q, vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         st_q, st_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LABEL_W-1:0] best_lab_q, best_lab_d;
    logic [CNT_W-1:0]   best_v_q, best_v_d;
    logic               rv_q, rv_d;
    logic [LABEL_W-1:0] rl_q, rl_d;
    logic [CNT_W-1:0]   rvo_q, rvo_d;

    logic [DATA_W-1:0]  rdd_q;
    logic [LABEL_W-1:0] rdl_q;
    logic               rdv_q;

    logic [K-1:0]       le;
    logic [K-1:0]       ins_here;
    logic               acc;
    logic               cls_go;
    logic [LABEL_W-1:0] cur_lab;
    logic [CNT_W-1:0]   votes;

    assign busy       = (st_q == S_SCAN);
    assign dist_ready = !busy;
    assign acc        = dist_valid && dist_ready && !clear;
    assign cls_go     = classify && !busy && !clear;

    // le is a prefix of ones; the new pair lands at the first zero
    always_comb begin
        for (int i = 0; i < K; i++) begin
            le[i] = vld_q[i] && (dist_q[i] <= dist_in);
        end
    end

    assign ins_here = ~le & {le[K-2:0], 1'b1};

    always_comb begin
        for (int i = 0; i < K; i++) begin
            dist_d[i] = dist_q[i];
            lab_d[i]  = lab_q[i];
            vld_d[i]  = vld_q[i];
        end
        if (acc) begin
            for (int i = 1; i < K; i++) begin
                if (!le[i] && !ins_here[i]) begin
                    dist_d[i] = dist_q[i-1];
                    lab_d[i]  = lab_q[i-1];
                    vld_d[i]  = vld_q[i-1];
                end
            end
            for (int i = 0; i < K; i++) begin
                if (ins_here[i]) begin
                    dist_d[i] = dist_in;
                    lab_d[i]  = label_in;
                    vld_d[i]  = 1'b1;
                end
            end
        end
        if (clear) begin
            vld_d = '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (acc && cnt_q != CNT_W'(K)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cur_lab = lab_q[idx_q];

    always_comb begin
        votes = '0;
        for (int j = 0; j < K; j++) begin
            if (vld_q[j] && lab_q[j] == cur_lab) begin
                votes = votes + CNT_W'(1);
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        best_lab_d = best_lab_q;
        best_v_d   = best_v_q;
        rv_d       = rv_q;
        rl_d       = rl_q;
        rvo_d      = rvo_q;
        unique case (st_q)
            S_SCAN: begin
                // strict compare keeps the closer entry on a tie
                if (vld_q[idx_q] && votes > best_v_q) begin
                    best_v_d   = votes;
                    best_lab_d = cur_lab;
                end
                if (idx_q == IDX_W'(K - 1)) begin
                    st_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                rv_d  = 1'b1;
                rl_d  = best_lab_q;
                rvo_d = best_v_q;
                st_d  = S_IDLE;
            end
            default: begin
            end
        endcase
        if (cls_go) begin
            rv_d       = 1'b0;
            idx_d      = '0;
            best_v_d   = '0;
            best_lab_d = '0;
            st_d       = (cnt_q == '0) ? S_DONE : S_SCAN;
        end
        if (acc) begin
            rv_d = 1'b0;
        end
        if (clear) begin
            st_d = S_IDLE;
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                lab_q[i]  <= '0;
            end
            vld_q      <= '0;
            cnt_q      <= '0;
            st_q       <= S_IDLE;
            idx_q      <= '0;
            best_lab_q <= '0;
            best_v_q   <= '0;
            rv_q       <= 1'b0;
            rl_q       <= '0;
            rvo_q      <= '0;
            rdd_q      <= '0;
            rdl_q      <= '0;
            rdv_q      <= 1'b0;
        end else begin
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= dist_d[i];
                lab_q[i]  <= lab_d[i];
            end
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
            st_q       <= st_d;
            idx_q      <= idx_d;
            best_lab_q <= best_lab_d;
            best_v_q   <= best_v_d;
            rv_q       <= rv_d;
            rl_q       <= rl_d;
            rvo_q      <= rvo_d;
            rdv_q      <= vld_q[rd_addr];
            rdd_q      <= vld_q[rd_addr] ? dist_q[rd_addr] : '0;
            rdl_q      <= vld_q[rd_addr] ? lab_q[rd_addr] : '0;
        end
    end

    assign count        = cnt_q;
    assign result_valid = rv_q;
    assign result_label = rl_q;
    assign result_votes = rvo_q;
    assign rd_dist      = rdd_q;
    assign rd_label     = rdl_q;
    assign rd_vld       = rdv_q;

endmodule

// File: tb/tb_knn_sort.sv
// Bench for knn_sort: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_knn_sort;

    localparam int DW = 32;
    localparam int LW = 4;
    localparam int K  = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          dist_valid = 1'b0;
    logic          classify = 1'b0;
    logic [DW-1:0] dist_in = '0;
    logic [LW-1:0] label_in = '0;
    logic [IW-1:0] rd_addr = '0;
    logic          dist_ready, busy, result_valid, rd_vld;
    logic [LW-1:0] result_label, rd_label;
    logic [CW-1:0] result_votes, count;
    logic [DW-1:0] rd_dist;

    knn_sort #(.DATA_W(DW), .LABEL_W(LW), .K(K)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .dist_valid(dist_valid), .dist_ready(dist_ready),
        .dist_in(dist_in), .label_in(label_in),
        .classify(classify), .busy(busy),
        .result_valid(result_valid), .result_label(result_label),
        .result_votes(result_votes), .count(count),
        .rd_addr(rd_addr), .rd_dist(rd_dist),
        .rd_label(rd_label), .rd_vld(rd_vld)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // reference model: sorted list as queues, vote computed up front
    logic [DW-1:0] m_d[$];
    logic [LW-1:0] m_l[$];
    int            m_cnt = 0;
    int            m_scan = 0;
    bit            m_done = 1'b0;
    bit            m_rv = 1'b0;
    int            m_pl = 0, m_pv = 0, m_rl = 0, m_rvo = 0;
    logic [DW-1:0] e_rdd = '0;
    logic [LW-1:0] e_rdl = '0;
    logic          e_rdv = 1'b0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_vote();
        int v;
        m_pl = 0;
        m_pv = 0;
        for (int i = 0; i < m_l.size(); i++) begin
            v = 0;
            for (int j = 0; j < m_l.size(); j++) if (m_l[j] == m_l[i]) v++;
            if (v > m_pv) begin
                m_pv = v;
                m_pl = int'(m_l[i]);
            end
        end
    endtask

    task automatic model_step();
        bit busy_now;
        int p;
        busy_now = (m_scan > 0);
        if (int'(rd_addr) < m_d.size()) begin
            e_rdd = m_d[rd_addr];
            e_rdl = m_l[rd_addr];
            e_rdv = 1'b1;
        end else begin
            e_rdd = '0;
            e_rdl = '0;
            e_rdv = 1'b0;
        end
        if (clear) begin
            m_d.delete();
            m_l.delete();
            m_cnt = 0;
            m_scan = 0;
            m_done = 1'b0;
            m_rv = 1'b0;
            return;
        end
        if (m_done) begin
            m_done = 1'b0;
            m_rv = 1'b1;
            m_rl = m_pl;
            m_rvo = m_pv;
        end else if (m_scan > 0) begin
            m_scan--;
            if (m_scan == 0) m_done = 1'b1;
        end
        if (classify && !busy_now) begin
            m_rv = 1'b0;
            model_vote();
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_scan = 0;
            end else begin
                m_done = 1'b0;
                m_scan = K;
            end
        end
        if (dist_valid && !busy_now) begin
            p = 0;
            for (int i = 0; i < m_d.size(); i++) if (m_d[i] <= dist_in) p++;
            if (p < K) begin
                m_d.insert(p, dist_in);
                m_l.insert(p, label_in);
                if (m_d.size() > K) begin
                    void'(m_d.pop_back());
                    void'(m_l.pop_back());
                end
            end
            if (m_cnt < K) m_cnt++;
            m_rv = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", count, m_cnt);
            check("dist_ready", dist_ready, m_scan == 0);
            check("busy", busy, m_scan > 0);
            check("result_valid", result_valid, m_rv);
            if (m_rv) begin
                check("result_label", result_label, m_rl);
                check("result_votes", result_votes, m_rvo);
            end
            check("rd_vld", rd_vld, e_rdv);
            check("rd_dist", rd_dist, e_rdd);
            check("rd_label", rd_label, e_rdl);
        end
    end

    task automatic tick(bit c = 0, bit dv = 0, logic [DW-1:0] d = 0,
                        logic [LW-1:0] l = 0, bit cl = 0);
        clear = c;
        dist_valid = dv;
        dist_in = d;
        label_in = l;
        classify = cl;
        @(posedge clk);
        model_step();
        #1;
        clear = 1'b0;
        dist_valid = 1'b0;
        classify = 1'b0;
    endtask

    task automatic ins(logic [DW-1:0] d, logic [LW-1:0] l);
        tick(0, 1, d, l, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", dist_ready, 1);
        check("rst_rv", result_valid, 0);
        check("rst_count", count, 0);
        check("rst_rlabel", result_label, 0);
        check("rst_rvotes", result_votes, 0);
        check("rst_rd_vld", rd_vld, 0);
        check("rst_rd_dist", rd_dist, 0);
        m_d.delete();
        m_l.delete();
        m_cnt = 0; m_scan = 0; m_done = 1'b0; m_rv = 1'b0;
        m_rl = 0; m_rvo = 0;
        e_rdd = '0; e_rdl = '0; e_rdv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic rd_check(int a, logic v, logic [DW-1:0] d, logic [LW-1:0] l);
        rd_addr = IW'(a);
        tick();
        check($sformatf("lit_rd_vld%0d", a), rd_vld, v);
        check($sformatf("lit_rd_dist%0d", a), rd_dist, d);
        check($sformatf("lit_rd_label%0d", a), rd_label, l);
    endtask

    // returns edges until result_valid and busy cycles seen
    task automatic run_vote(output int e, output int nb);
        tick(0, 0, 0, 0, 1);
        e = 0;
        nb = 0;
        while (e < 20 && !result_valid) begin
            if (busy) nb++;
            tick();
            e++;
        end
    endtask

    int e, nb;

    initial begin
        #2;
        do_reset();
        for (int a = 0; a < K; a++) rd_check(a, 0, 0, 0);

        ins(50, 1); ins(20, 2); ins(70, 3); ins(20, 3); ins(10, 1);
        check("lit_count_full", count, 4);
        rd_check(0, 1, 10, 1);
        rd_check(1, 1, 20, 2);
        rd_check(2, 1, 20, 3);
        rd_check(3, 1, 50, 1);

        run_vote(e, nb);
        check("lit_vote_latency", e, 5);
        check("lit_vote_busy", nb, 4);
        check("lit_vote_label", result_label, 1);
        check("lit_vote_votes", result_votes, 2);

        tick(1);
        ins(5, 2); ins(6, 3); ins(7, 2); ins(8, 3);
        run_vote(e, nb);
        check("lit_tie_rv", result_valid, 1);
        check("lit_tie_label", result_label, 2);
        check("lit_tie_votes", result_votes, 2);
        ins(9, 1);
        check("lit_disc_rv", result_valid, 0);
        check("lit_disc_count", count, 4);
        rd_check(3, 1, 8, 3);

        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < K; i++) begin
            check("lit_bp_ready", dist_ready, 0);
            tick(0, 1, 1, 5, 1);
        end
        check("lit_bp_count", count, 4);
        e = 0;
        while (e < 20 && !result_valid) begin
            tick();
            e++;
        end
        check("lit_bp_rv", result_valid, 1);
        check("lit_bp_label", result_label, 2);
        rd_check(0, 1, 5, 2);

        tick(0, 0, 0, 0, 1);
        tick();
        tick(1);
        check("lit_clr_busy", busy, 0);
        check("lit_clr_count", count, 0);
        check("lit_clr_rv", result_valid, 0);
        run_vote(e, nb);
        check("lit_empty_latency", e, 1);
        check("lit_empty_label", result_label, 0);
        check("lit_empty_votes", result_votes, 0);

        ins(3, 7); ins(1, 7);
        tick(0, 0, 0, 0, 1);
        tick();
        #3;
        do_reset();
        tick();
        check("lit_post_rst_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
